unified_mem_arbiter: RTL and testbench

Shares one single-port, variable-latency external memory between the core's instruction-fetch port and its load/store port. It sits between the pipeline top level and memory and generates the pipeline's global stall. For each core step it runs at most one load/store access, then one fetch, then releases the pipeline for exactly one cycle with both results held stable.

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter.sv | 109 ++++++++++
 tb/tb_unified_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared widths and FSM state encoding for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

   localparam int WORD  = 32;
   localparam int ADDR  = 32;
   localparam int W_OPR = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LDST  = 2'd1,
      S_FETCH = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Serialises one load/store access and one instruction fetch per core step onto a
// single-port variable-latency memory, stalling the core until both have completed.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int P_WORD  = WORD,
   parameter int P_ADDR  = ADDR,
   parameter int P_W_OPR = W_OPR,
   parameter int P_RD_W  = max_w(P_WORD, P_W_OPR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [P_ADDR-1:0]  inst_addr_i,
   output logic [P_WORD-1:0]  inst_o,
   input  logic               ldst_req_i,
   input  logic               ldst_write_i,
   input  logic [P_ADDR-1:0]  ldst_addr_i,
   input  logic [P_W_OPR-1:0] ldst_data_i,
   output logic [P_W_OPR-1:0] ldst_data_o,
   input  logic               hlt_i,
   output logic               stall_o,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic [P_ADDR-1:0]  mem_addr_o,
   output logic [P_W_OPR-1:0] mem_wdata_o,
   input  logic [P_RD_W-1:0]  mem_rdata_i,
   input  logic               mem_ack_i
);

   state_e             state_q;
   logic [P_ADDR-1:0]  inst_addr_q;
   logic [P_WORD-1:0]  inst_q;
   logic [P_W_OPR-1:0] ldst_data_q;
   logic               stall_q;
   logic               mem_req_q;
   logic               mem_we_q;
   logic [P_ADDR-1:0]  mem_addr_q;
   logic [P_W_OPR-1:0] mem_wdata_q;

   // The memory-side registers double as the latched load/store request:
   // mem_we_q remembers load vs. store until the data ack arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         inst_addr_q <= '0;
         inst_q      <= '0;
         ldst_data_q <= '0;
         stall_q     <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!hlt_i) begin
                  inst_addr_q <= inst_addr_i;
                  mem_req_q   <= 1'b1;
                  if (ldst_req_i) begin
                     state_q     <= S_LDST;
                     mem_we_q    <= ldst_write_i;
                     mem_addr_q  <= ldst_addr_i;
                     mem_wdata_q <= ldst_data_i;
                  end else begin
                     state_q    <= S_FETCH;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= inst_addr_i;
                  end
               end
            end
            S_LDST: begin
               if (mem_ack_i) begin
                  if (!mem_we_q) begin
                     ldst_data_q <= mem_rdata_i[P_W_OPR-1:0];
                  end
                  // Request stays high; the fetch starts on the very next cycle.
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= inst_addr_q;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (mem_ack_i) begin
                  inst_q    <= mem_rdata_i[P_WORD-1:0];
                  mem_req_q <= 1'b0;
                  stall_q   <= 1'b0;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               stall_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign inst_o      = inst_q;
   assign ldst_data_o = ldst_data_q;
   assign stall_o     = stall_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural wait-state memory model.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] inst_addr_i;
   logic [31:0] inst_o;
   logic        ldst_req_i;
   logic        ldst_write_i;
   logic [31:0] ldst_addr_i;
   logic [31:0] ldst_data_i;
   logic [31:0] ldst_data_o;
   logic        hlt_i;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int tests_run = 0;
   int tests_failed = 0;

   // memory model state
   int          wait_cycles = 0;
   int          wcnt = 0;
   logic        model_ack = 1'b0;
   logic [31:0] model_rdata = '0;
   logic        man_en = 1'b0;
   logic        man_ack = 1'b0;
   logic [31:0] man_rdata = '0;

   // transaction log and activity counters, only ever incremented by the monitor
   logic [31:0] log_addr [64];
   logic        log_we [64];
   logic [31:0] log_wdata [64];
   int          log_n = 0;
   int          req_cyc = 0;
   int          req_rise = 0;
   int          stall_low = 0;
   logic        req_prev = 1'b0;

   assign mem_ack_i   = man_en ? man_ack : model_ack;
   assign mem_rdata_i = man_en ? man_rdata : model_rdata;

   unified_mem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .inst_addr_i  (inst_addr_i),
      .inst_o       (inst_o),
      .ldst_req_i   (ldst_req_i),
      .ldst_write_i (ldst_write_i),
      .ldst_addr_i  (ldst_addr_i),
      .ldst_data_i  (ldst_data_i),
      .ldst_data_o  (ldst_data_o),
      .hlt_i        (hlt_i),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h1234_5678;
         32'h0000_0040: return 32'hDEAD_BEEF;
         32'h0000_0044: return 32'hCAFE_F00D;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Ack is presented at the falling edge so the DUT samples it on the next rising edge;
   // wait_cycles extra request cycles precede each ack.
   always @(negedge clk) begin
      if (mem_req_o) req_cyc++;
      if (mem_req_o && !req_prev) req_rise++;
      if (!stall_o) stall_low++;
      req_prev = mem_req_o;
      if (reset || !mem_req_o) begin
         model_ack = 1'b0;
         wcnt = 0;
      end else if (wcnt >= wait_cycles) begin
         model_ack   = 1'b1;
         model_rdata = mem_we_o ? 32'h0 : mem_read(mem_addr_o);
         if (log_n < 64) begin
            log_addr[log_n]  = mem_addr_o;
            log_we[log_n]    = mem_we_o;
            log_wdata[log_n] = mem_wdata_o;
            log_n++;
         end
         wcnt = 0;
      end else begin
         model_ack = 1'b0;
         wcnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Runs one core step starting in IDLE; returns the cycle number (IDLE cycle = 1)
   // in which stall_o is first seen low. hlt_i is re-raised right after sampling,
   // so every step also exercises a mid-step halt.
   task automatic do_step(input logic [31:0] ia, input logic req, input logic wr,
                          input logic [31:0] la, input logic [31:0] ld,
                          input logic scramble, output int cycles);
      int k;
      inst_addr_i  = ia;
      ldst_req_i   = req;
      ldst_write_i = wr;
      ldst_addr_i  = la;
      ldst_data_i  = ld;
      hlt_i        = 1'b0;
      @(posedge clk); #1;
      hlt_i = 1'b1;
      k = 1;
      while (stall_o && k < 60) begin
         if (scramble) begin
            inst_addr_i  = 32'h1000_0000 + k * 32'h10;
            ldst_addr_i  = 32'h2000_0000 + k * 32'h10;
            ldst_write_i = ~ldst_write_i;
            ldst_req_i   = ~ldst_req_i;
         end
         @(posedge clk); #1;
         k++;
      end
      cycles = stall_o ? -1 : k + 1;
      if (stall_o) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL step_timeout: stall_o still 1 after %0d cycles, required a release", k);
      end
      @(posedge clk); #1;
      check_eq("stall_single_cycle", {31'b0, stall_o}, 32'h1);
   endtask

   initial begin
      int cyc;
      int base;
      int rc0;
      int rr0;
      int sl0;

      reset = 1'b1;
      hlt_i = 1'b1;
      inst_addr_i = '0;
      ldst_req_i = 1'b0;
      ldst_write_i = 1'b0;
      ldst_addr_i = '0;
      ldst_data_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_stall", {31'b0, stall_o}, 32'h1);
      check_eq("rst_req", {31'b0, mem_req_o}, 32'h0);
      check_eq("rst_we", {31'b0, mem_we_o}, 32'h0);
      check_eq("rst_addr", mem_addr_o, 32'h0);
      check_eq("rst_wdata", mem_wdata_o, 32'h0);
      check_eq("rst_inst", inst_o, 32'h0);
      check_eq("rst_ldst", ldst_data_o, 32'h0);
      reset = 1'b0;

      // fetch only, zero-wait
      wait_cycles = 0;
      rc0 = req_cyc;
      base = log_n;
      do_step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, cyc);
      check_eq("fetch_cycles", cyc, 3);
      check_eq("fetch_inst", inst_o, 32'h1234_5678);
      check_eq("fetch_req_cycles", req_cyc - rc0, 1);
      check_eq("fetch_txn_count", log_n - base, 1);

      // load 0x40 then fetch 0x4, one wait state per transaction
      wait_cycles = 1;
      rc0 = req_cyc;
      rr0 = req_rise;
      base = log_n;
      do_step(32'h4, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, cyc);
      check_eq("load_cycles", cyc, 6);
      check_eq("load_data", ldst_data_o, 32'hDEAD_BEEF);
      check_eq("load_inst", inst_o, 32'h5A5A_0004);
      check_eq("load_first_addr", log_addr[base], 32'h40);
      check_eq("load_second_addr", log_addr[base+1], 32'h4);
      check_eq("load_req_rises", req_rise - rr0, 1);
      check_eq("load_req_cycles", req_cyc - rc0, 4);

      // store 0xA5A5A5A5 to 0x80, fetch 0x8, zero-wait
      wait_cycles = 0;
      base = log_n;
      do_step(32'h8, 1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b0, cyc);
      check_eq("store_cycles", cyc, 4);
      check_eq("store_addr", log_addr[base], 32'h80);
      check_eq("store_we", {31'b0, log_we[base]}, 32'h1);
      check_eq("store_wdata", log_wdata[base], 32'hA5A5_A5A5);
      check_eq("store_fetch_we", {31'b0, log_we[base+1]}, 32'h0);
      check_eq("store_fetch_addr", log_addr[base+1], 32'h8);
      check_eq("store_keeps_ldst", ldst_data_o, 32'hDEAD_BEEF);
      check_eq("store_inst", inst_o, 32'h5A5A_0008);

      // inputs change every cycle while waiting on memory
      wait_cycles = 2;
      base = log_n;
      do_step(32'hC, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, cyc);
      check_eq("scr_cycles", cyc, 8);
      check_eq("scr_ldst_addr", log_addr[base], 32'h44);
      check_eq("scr_ldst_we", {31'b0, log_we[base]}, 32'h0);
      check_eq("scr_fetch_addr", log_addr[base+1], 32'hC);
      check_eq("scr_load_data", ldst_data_o, 32'hCAFE_F00D);
      check_eq("scr_inst", inst_o, 32'h5A5A_000C);

      // halted in IDLE for 20 cycles
      rc0 = req_cyc;
      sl0 = stall_low;
      repeat (20) @(posedge clk);
      #1;
      check_eq("hlt_req_cycles", req_cyc - rc0, 0);
      check_eq("hlt_stall_lows", stall_low - sl0, 0);
      check_eq("hlt_stall", {31'b0, stall_o}, 32'h1);

      // reset during LDST_WAIT with an ack pending
      wait_cycles = 100;
      inst_addr_i = 32'h0;
      ldst_req_i = 1'b1;
      ldst_write_i = 1'b0;
      ldst_addr_i = 32'h40;
      hlt_i = 1'b0;
      @(posedge clk); #1;
      hlt_i = 1'b1;
      @(posedge clk); #1;
      check_eq("pre_rst_req", {31'b0, mem_req_o}, 32'h1);
      reset = 1'b1;
      #1;
      check_eq("async_rst_req", {31'b0, mem_req_o}, 32'h0);
      check_eq("async_rst_ldst", ldst_data_o, 32'h0);
      man_en = 1'b1;
      man_ack = 1'b1;
      man_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      man_ack = 1'b0;
      man_en = 1'b0;
      check_eq("late_ack_ldst", ldst_data_o, 32'h0);
      check_eq("late_ack_inst", inst_o, 32'h0);
      check_eq("late_ack_req", {31'b0, mem_req_o}, 32'h0);
      check_eq("late_ack_stall", {31'b0, stall_o}, 32'h1);

      wait_cycles = 0;
      base = log_n;
      do_step(32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, cyc);
      check_eq("post_rst_cycles", cyc, 3);
      check_eq("post_rst_addr", log_addr[base], 32'h10);
      check_eq("post_rst_inst", inst_o, 32'h5A5A_0010);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
